// File: rtl/cpu_mem_resp_if.sv
// Bundle of the CPU instruction/data port, host load handshake and status lines
// between cpu_mem_resp and its surroundings. DD is bidirectional and stays a plain port.
interface cpu_mem_resp_if;
  logic [15:0] IA;
  logic [15:0] ID;
  logic [15:0] DA;
  logic        RW;
  logic        CPU_RST;
  logic        RUNNING;
  logic        LD_VALID;
  logic        LD_READY;
  logic        LD_SEL;
  logic [15:0] LD_ADDR;
  logic [15:0] LD_DATA;
  logic        LD_DONE;
  logic        LD_REQ;
  logic [15:0] DWCNT;
  logic        dbg_state;
  logic        dd_oe;

  modport slave (
    input  IA, DA, RW, LD_VALID, LD_SEL, LD_ADDR, LD_DATA, LD_DONE, LD_REQ,
    output ID, CPU_RST, RUNNING, LD_READY, DWCNT, dbg_state, dd_oe
  );

  modport master (
    output IA, DA, RW, LD_VALID, LD_SEL, LD_ADDR, LD_DATA, LD_DONE, LD_REQ,
    input  ID, CPU_RST, RUNNING, LD_READY, DWCNT, dbg_state, dd_oe
  );
endinterface

// File: rtl/cpu_mem_resp.sv
// Memory-side responder: instruction/data RAMs plus a LOAD/RUN controller that keeps
// the CPU in reset while the host writes images, then serves fetches, loads and stores.
module cpu_mem_resp #(
    parameter int IAW = 8,
    parameter int DAW = 8
) (
    input  logic        CK,
    input  logic        RST,
    inout  wire  [15:0] DD,
    cpu_mem_resp_if.slave bus
);

    // Host handshake: a load write happens on every edge where LD_VALID && LD_READY;
    // LD_READY is high exactly in LOAD, so there is no back-pressure inside LOAD.
    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } st_t;

    st_t         st;
    st_t         st_nx;
    logic        ld_we;
    logic        cpu_we;
    logic        dd_oe;
    logic [15:0] dwcnt;

    logic [15:0] imem [2**IAW];
    logic [15:0] dmem [2**DAW];

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) st <= S_LOAD;
        else      st <= st_nx;
    end

    // LD_REQ is checked first so it wins over a simultaneous LD_DONE in RUN.
    always_comb begin
        st_nx = st;
        case (st)
            S_LOAD:  if (bus.LD_DONE) st_nx = S_RUN;
            S_RUN:   if (bus.LD_REQ)  st_nx = S_LOAD;
            default: st_nx = S_LOAD;
        endcase
    end

    always_comb begin
        bus.CPU_RST   = (st == S_LOAD);
        bus.RUNNING   = (st == S_RUN);
        bus.LD_READY  = (st == S_LOAD);
        bus.dbg_state = st;
        ld_we         = (st == S_LOAD) && bus.LD_VALID && RST;
        cpu_we        = (st == S_RUN) && !bus.RW;
        dd_oe         = (st == S_RUN) && bus.RW;
    end

    assign bus.dd_oe = dd_oe;
    assign bus.DWCNT = dwcnt;

    // RW=0 drops the driver in the same cycle, so the CPU never fights us on DD.
    assign DD     = dd_oe ? dmem[bus.DA[DAW-1:0]] : 16'hzzzz;
    assign bus.ID = imem[bus.IA[IAW-1:0]];

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            dwcnt <= 16'h0000;
        end else if (st == S_LOAD) begin
            if (bus.LD_DONE) dwcnt <= 16'h0000;
        end else if (cpu_we && dwcnt != 16'hFFFF) begin
            dwcnt <= dwcnt + 16'h0001;
        end
    end

    always_ff @(posedge CK) begin
        if (ld_we && !bus.LD_SEL) imem[bus.LD_ADDR[IAW-1:0]] <= bus.LD_DATA;
    end

    always_ff @(posedge CK) begin
        if (ld_we && bus.LD_SEL) dmem[bus.LD_ADDR[DAW-1:0]] <= bus.LD_DATA;
        else if (cpu_we)         dmem[bus.DA[DAW-1:0]]      <= DD;
    end

endmodule

// File: tb/tb_cpu_mem_resp.sv
// Bench for cpu_mem_resp: fixed load/read vectors, hand-written race sequences and a
// randomized CPU traffic phase checked against an array-based memory model.
module tb_cpu_mem_resp;
  logic        CK;
  logic        RST;
  wire  [15:0] DD;
  logic [15:0] cpu_dout;

  cpu_mem_resp_if bus();

  cpu_mem_resp #(.IAW(8), .DAW(8)) dut (
    .CK  (CK),
    .RST (RST),
    .DD  (DD),
    .bus (bus)
  );

  // the bench plays the CPU: it drives DD only while RW=0
  assign DD = bus.RW ? 16'hzzzz : cpu_dout;

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;

  logic [15:0] imem_m [256];
  logic [15:0] dmem_m [256];
  logic        m_run;
  logic [15:0] m_cnt;

  typedef struct {
    logic        sel;
    logic [15:0] ld_addr;
    logic [15:0] data;
    logic [15:0] rd_addr;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // applies the memory rules for the coming edge to the model, then takes the edge
  task automatic step();
    if (!m_run) begin
      if (bus.LD_VALID) begin
        if (bus.LD_SEL) dmem_m[bus.LD_ADDR[7:0]] = bus.LD_DATA;
        else            imem_m[bus.LD_ADDR[7:0]] = bus.LD_DATA;
      end
      if (bus.LD_DONE) begin
        m_run = 1'b1;
        m_cnt = 16'h0000;
      end
    end else begin
      if (!bus.RW) begin
        dmem_m[bus.DA[7:0]] = cpu_dout;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
      end
      if (bus.LD_REQ) m_run = 1'b0;
    end
    @(posedge CK);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".id"},      bus.ID, imem_m[bus.IA[7:0]]);
    chk({tag, ".running"}, {15'b0, bus.RUNNING},   {15'b0, m_run});
    chk({tag, ".cpu_rst"}, {15'b0, bus.CPU_RST},   {15'b0, ~m_run});
    chk({tag, ".ready"},   {15'b0, bus.LD_READY},  {15'b0, ~m_run});
    chk({tag, ".state"},   {15'b0, bus.dbg_state}, {15'b0, m_run});
    chk({tag, ".dd_oe"},   {15'b0, bus.dd_oe},     {15'b0, m_run & bus.RW});
    chk({tag, ".dwcnt"},   bus.DWCNT, m_cnt);
    if (m_run && bus.RW) chk({tag, ".dd"}, DD, dmem_m[bus.DA[7:0]]);
  endtask

  task automatic idle();
    bus.LD_VALID = 1'b0;
    bus.LD_DONE  = 1'b0;
    bus.LD_REQ   = 1'b0;
    bus.RW       = 1'b1;
  endtask

  task automatic host_write(input logic sel, input logic [15:0] addr, input logic [15:0] data);
    bus.LD_VALID = 1'b1;
    bus.LD_SEL   = sel;
    bus.LD_ADDR  = addr;
    bus.LD_DATA  = data;
    step();
    bus.LD_VALID = 1'b0;
  endtask

  task automatic start_run();
    bus.LD_DONE = 1'b1;
    step();
    bus.LD_DONE = 1'b0;
  endtask

  task automatic cpu_store(input logic [15:0] addr, input logic [15:0] data);
    bus.RW   = 1'b0;
    bus.DA   = addr;
    cpu_dout = data;
    step();
    bus.RW   = 1'b1;
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] old;

    vt[0] = '{1'b0, 16'h0000, 16'hC105, 16'h0000, 16'hC105};
    vt[1] = '{1'b1, 16'h0003, 16'h00AA, 16'h0003, 16'h00AA};
    vt[2] = '{1'b0, 16'h0005, 16'h1357, 16'h0105, 16'h1357};
    vt[3] = '{1'b0, 16'hFF0A, 16'h2468, 16'h000A, 16'h2468};
    vt[4] = '{1'b1, 16'h00FF, 16'hFFFF, 16'hABFF, 16'hFFFF};
    vt[5] = '{1'b1, 16'h0180, 16'h0001, 16'h0080, 16'h0001};

    RST = 1'b0;
    bus.IA = 16'h0000; bus.DA = 16'h0000; bus.LD_SEL = 1'b0;
    bus.LD_ADDR = 16'h0000; bus.LD_DATA = 16'h0000; cpu_dout = 16'h0000;
    idle();
    m_run = 1'b0;
    m_cnt = 16'h0000;

    // reset state, held two edges
    repeat (2) @(posedge CK);
    #1;
    RST = 1'b1;
    #1;
    chk("rst.cpu_rst", {15'b0, bus.CPU_RST},  16'h0001);
    chk("rst.ready",   {15'b0, bus.LD_READY}, 16'h0001);
    chk("rst.running", {15'b0, bus.RUNNING},  16'h0000);
    chk("rst.dwcnt",   bus.DWCNT,             16'h0000);
    chk("rst.dd_oe",   {15'b0, bus.dd_oe},    16'h0000);

    // fill every location so nothing read later is X
    for (int i = 0; i < 256; i++) host_write(1'b0, i[15:0], 16'($urandom));
    for (int i = 0; i < 256; i++) host_write(1'b1, i[15:0], 16'($urandom));
    for (int i = 0; i < 6; i++) host_write(vt[i].sel, vt[i].ld_addr, vt[i].data);

    bus.IA = 16'h0000;
    bus.DA = 16'h0003;
    #1;
    chk("load.id0", bus.ID, 16'hC105);
    chk("load.dd_released", {15'b0, bus.dd_oe}, 16'h0000);
    check_all("load");

    start_run();
    chk("run.cpu_rst", {15'b0, bus.CPU_RST},  16'h0000);
    chk("run.running", {15'b0, bus.RUNNING},  16'h0001);
    chk("run.ready",   {15'b0, bus.LD_READY}, 16'h0000);
    chk("run.dwcnt",   bus.DWCNT,             16'h0000);
    chk("run.dd3",     DD,                    16'h00AA);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].sel) begin
        bus.DA = vt[i].rd_addr;
        #1;
        chk($sformatf("vec%0d.dd", i), DD, vt[i].exp);
      end else begin
        bus.IA = vt[i].rd_addr;
        #1;
        chk($sformatf("vec%0d.id", i), bus.ID, vt[i].exp);
      end
    end

    // single store, then wrapped read-back
    cpu_store(16'h0010, 16'h1234);
    bus.DA = 16'h0110;
    #1;
    chk("store.dd_wrap", DD, 16'h1234);
    chk("store.dwcnt",   bus.DWCNT, 16'h0001);

    // small program: load two words, store their sum, read it back
    bus.DA = 16'h0003; #1; a = DD;
    bus.DA = 16'h0080; #1; b = DD;
    cpu_store(16'h0040, a + b);
    bus.DA = 16'h0040;
    #1;
    chk("prog.sum",   DD, 16'h00AB);
    chk("prog.dwcnt", bus.DWCNT, 16'h0002);

    // RW=0 held three cycles: three writes, last value wins
    bus.RW = 1'b0;
    bus.DA = 16'h0050;
    cpu_dout = 16'h1111; step();
    cpu_dout = 16'h2222; step();
    cpu_dout = 16'h3333; step();
    bus.RW = 1'b1;
    #1;
    chk("multi.dd",    DD, 16'h3333);
    chk("multi.dwcnt", bus.DWCNT, 16'h0005);

    // host writes ignored in RUN
    host_write(1'b0, 16'h0000, 16'hFFFF);
    bus.IA = 16'h0000;
    #1;
    chk("rej.id0",   bus.ID, 16'hC105);
    chk("rej.ready", {15'b0, bus.LD_READY}, 16'h0000);

    // randomized CPU traffic with host noise
    for (int i = 0; i < 300; i++) begin
      bus.IA       = 16'($urandom);
      bus.DA       = 16'($urandom);
      bus.RW       = ($urandom_range(0, 2) != 0);
      cpu_dout     = 16'($urandom);
      bus.LD_VALID = ($urandom_range(0, 3) == 0);
      bus.LD_SEL   = 1'($urandom);
      bus.LD_ADDR  = 16'($urandom);
      bus.LD_DATA  = 16'($urandom);
      bus.LD_DONE  = ($urandom_range(0, 7) == 0);
      #1;
      check_all("rand");
      step();
    end
    idle();
    #1;
    check_all("rand_end");

    // LD_REQ and LD_DONE together: back to LOAD, count held
    old = m_cnt;
    bus.LD_REQ  = 1'b1;
    bus.LD_DONE = 1'b1;
    step();
    idle();
    #1;
    chk("req.cpu_rst", {15'b0, bus.CPU_RST}, 16'h0001);
    chk("req.dwcnt_hold", bus.DWCNT, old);
    check_all("req");

    // LD_VALID with LD_DONE in LOAD: write lands and RUN is entered
    bus.LD_VALID = 1'b1;
    bus.LD_SEL   = 1'b0;
    bus.LD_ADDR  = 16'h0007;
    bus.LD_DATA  = 16'hBEEF;
    bus.LD_DONE  = 1'b1;
    step();
    idle();
    bus.IA = 16'h0007;
    #1;
    chk("race.running", {15'b0, bus.RUNNING}, 16'h0001);
    chk("race.id7",     bus.ID, 16'hBEEF);
    check_all("race");

    // reset asserted while a store is pending: no write, back to LOAD
    old = dmem_m[8'h20];
    bus.RW   = 1'b0;
    bus.DA   = 16'h0020;
    cpu_dout = ~old;
    #1;
    RST = 1'b0;
    @(posedge CK);
    #1;
    bus.RW = 1'b1;
    RST = 1'b1;
    m_run = 1'b0;
    m_cnt = 16'h0000;
    #1;
    chk("rstw.state", {15'b0, bus.dbg_state}, 16'h0000);
    chk("rstw.cpu_rst", {15'b0, bus.CPU_RST}, 16'h0001);
    check_all("rstw");
    start_run();
    bus.DA = 16'h0020;
    #1;
    chk("rstw.word_kept", DD, old);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_mem_resp.md
Name: cpu_mem_resp

Overview:
- Memory-side responder for the 16-bit simple microprocessor. Serves its instruction port (IA/ID) and its data port (DA/DD/RW).
- Owns the instruction and data RAMs. Contains a host load controller that holds the CPU in reset while a host writes the program and data images, then releases it.
- Sits at top level between the CPU and the test/host loader.

Parameters:
- IAW, 8, instruction address bits used (IMEM depth 2**IAW words of 16 bits).
- DAW, 8, data address bits used (DMEM depth 2**DAW words of 16 bits).

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- IA  input  16  CPU instruction address.
- ID  output  16  instruction word = IMEM[IA[IAW-1:0]].
- DA  input  16  CPU data address.
- DD  inout  16  CPU data bus; driven by this block only when reading.
- RW  input  1  CPU direction: 1 = read (block drives DD), 0 = write (CPU drives DD).
- CPU_RST  output  1  active-high synchronous reset to the CPU.
- RUNNING  output  1  1 in RUN state.
- LD_VALID  input  1  host write request.
- LD_READY  output  1  block accepts host write.
- LD_SEL  input  1  0 = IMEM, 1 = DMEM.
- LD_ADDR  input  16  host word address (low IAW/DAW bits used).
- LD_DATA  input  16  host write data.
- LD_DONE  input  1  host finished loading; start CPU.
- LD_REQ  input  1  request return to LOAD from RUN.
- DWCNT  output  16  count of CPU data writes since entering RUN, saturating.

Behaviour:
- Reset is asynchronous and active-low; entered immediately on RST=0. Reset values:
  - state=LOAD, CPU_RST=1, RUNNING=0, LD_READY=1, DWCNT=0, DD released (Z).
  - Memory contents are not reset.
- States: LOAD, RUN.
- LOAD:
  - CPU_RST=1, LD_READY=1.
  - Every edge with LD_VALID=1 writes LD_DATA into the memory selected by LD_SEL, at the truncated LD_ADDR. Handshake completes that same edge (valid&ready).
  - RW and DD are ignored for writes.
  - LD_DONE=1 at an edge: state<=RUN, CPU_RST<=0, RUNNING<=1, LD_READY<=0, DWCNT<=0.
  - LD_VALID and LD_DONE together: the write is performed, then the transition.
- RUN:
  - LD_READY=0; LD_VALID is ignored, with no write and no error.
  - LD_REQ=1 at an edge: state<=LOAD, CPU_RST<=1, RUNNING<=0, LD_READY<=1. DWCNT holds its value.
  - LD_REQ and LD_DONE together in RUN: LD_REQ wins.
- Instruction port:
  - ID is combinational from IA, with zero latency, in every state.
  - Required because the CPU samples ID on the first edge after PC changes.
- Data read:
  - In RUN with RW=1, DD = DMEM[DA[DAW-1:0]] combinationally.
  - Required because the CPU latches DD one edge after DA settles.
  - In LOAD, or when RW=0, DD is Z.
- Data write:
  - In RUN, every edge with RW=0 writes DD into DMEM[DA[DAW-1:0]] and increments DWCNT, saturating at 16'hFFFF.
  - The CPU holds RW=0 for exactly one cycle per store, so each store writes once.
  - RW=0 lasting N cycles performs N writes to the same address; last value wins.
- Address wrap: upper address bits are ignored. IA=16'h0105 with IAW=8 reads IMEM[5].
- DD contention is forbidden: the block's DD driver must be disabled combinationally from RW=0 within the same cycle.
- Reset mid-operation (RW=0 or LD_VALID pending): no write occurs, and the block returns to LOAD with CPU_RST=1.
- Reading never-written locations returns X in simulation. Benches load all locations they read.

Test Plan:
- Reset then load: RST low 2 cycles, release → CPU_RST=1, LD_READY=1, DD=Z. Write IMEM[0]=16'hC105 and DMEM[3]=16'h00AA → ID=16'hC105 when IA=0. DMEM unobservable on DD in LOAD (Z).
- Start: LD_DONE pulse → next edge CPU_RST=0, RUNNING=1, LD_READY=0, DWCNT=0. RW=1, DA=3 → DD=16'h00AA in the same cycle.
- CPU store: RW=0 for one cycle, DA=16'h0010, CPU drives 16'h1234 → DMEM[16]=16'h1234, DWCNT=1. Then RW=1, DA=16'h0110 → DD=16'h1234 (wrap).
- Program run: load an 8-instruction program (set immediates, add, store, load, jump), then LD_DONE → the CPU's final stored value matches the golden result. DWCNT equals the number of stores.
- Host writes rejected in RUN: LD_VALID=1, LD_SEL=0, LD_ADDR=0, LD_DATA=16'hFFFF → ID at IA=0 unchanged, LD_READY=0.
- Return and races:
  - LD_REQ and LD_DONE together in RUN → LOAD, CPU_RST=1.
  - In LOAD, LD_VALID and LD_DONE together → write landed and RUN entered.
  - RST low during RW=0 → target word unchanged, state LOAD.
